sdram_burst_arbiter: RTL

- Schedules the shared SDRAM between three requesters in the 100 MHz SDRAM domain: periodic auto-refresh, write bursts draining the UART-side write FIFO, and read bursts filling the TFT-side read FIFO.
- Owns the write and read burst address counters, including base/max wrap and reload.
- Issues one command at a time to the SDRAM command engine over a req/ack/done handshake.

---
 rtl/sdram_burst_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: schedules refresh, write bursts and read bursts onto one SDRAM command engine
module sdram_burst_arbiter #(
   parameter int BURST_LEN     = 8,
   parameter int REF_PERIOD    = 780,
   parameter int ADDR_W        = 24,
   parameter int USE_W         = 10,
   parameter int RD_FIFO_DEPTH = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic [USE_W-1:0]  wr_use,
   input  logic [USE_W-1:0]  rd_use,
   input  logic              rd_enable,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic [ADDR_W-1:0] wr_max,
   input  logic              wr_load,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W-1:0] rd_max,
   input  logic              rd_load,
   output logic              cmd_req,
   output logic [1:0]        cmd_type,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_ack,
   input  logic              cmd_done,
   output logic              busy,
   output logic              ref_pend
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_REF  = 2'b01;
   localparam logic [1:0] T_WR   = 2'b10;
   localparam logic [1:0] T_RD   = 2'b11;
   localparam int RCW = $clog2(REF_PERIOD + 1);
   localparam logic [RCW-1:0]   REF_LAST = RCW'(REF_PERIOD - 1);
   localparam logic [USE_W-1:0] RD_LIM   = USE_W'(RD_FIFO_DEPTH - BURST_LEN);
   localparam logic [USE_W-1:0] RD_HALF  = USE_W'(RD_FIFO_DEPTH / 2);
   localparam logic [USE_W-1:0] WR_LIM   = USE_W'(BURST_LEN);
   localparam logic [ADDR_W:0]  STEP     = (ADDR_W + 1)'(BURST_LEN);

   state_t            r_state, w_next;
   logic [RCW-1:0]    r_cnt;
   logic              r_pend, r_rr;
   logic [ADDR_W-1:0] r_wr_addr, r_rd_addr, r_addr;
   logic [1:0]        r_type, w_sel;
   logic              w_rd_elig, w_rd_urg, w_wr_elig, w_rr_hit, w_go, w_fin, w_tick, w_ref_ack;
   logic [ADDR_W:0]   w_wr_nxt, w_rd_nxt;

   assign w_rd_elig = rd_enable & (rd_use <= RD_LIM);
   assign w_rd_urg  = w_rd_elig & (rd_use < RD_HALF);
   assign w_wr_elig = wr_use >= WR_LIM;
   assign w_tick    = init_done & (r_cnt == REF_LAST);
   assign w_ref_ack = (r_state == S_REQ) & cmd_ack & (r_type == T_REF);
   assign w_fin     = (r_state == S_WAIT) & cmd_done;
   assign w_wr_nxt  = {1'b0, r_wr_addr} + STEP;
   assign w_rd_nxt  = {1'b0, r_rd_addr} + STEP;

   assign cmd_req  = r_state == S_REQ;
   assign cmd_type = r_type;
   assign cmd_addr = r_addr;
   assign busy     = r_state != S_IDLE;
   assign ref_pend = r_pend;

   // Priority selection in IDLE and the REQ/WAIT handshake progression
   always_comb begin
      w_sel    = r_pend ? T_REF : w_rd_urg ? T_RD : (w_rd_elig & w_wr_elig) ? (r_rr ? T_WR : T_RD) :
                 w_rd_elig ? T_RD : w_wr_elig ? T_WR : T_NONE;
      w_rr_hit = ~r_pend & ~w_rd_urg & w_rd_elig & w_wr_elig;
      w_go     = (r_state == S_IDLE) & init_done & (w_sel != T_NONE);
      w_next   = w_go ? S_REQ :
                 ((r_state == S_REQ) & cmd_ack) ? S_WAIT :
                 w_fin ? S_IDLE : r_state;
   end

   // State register
   always_ff @(posedge clk) begin
      r_state <= rst ? S_IDLE : w_next;
   end

   // Command latch: captured at the decision, held through REQ/WAIT, cleared on completion
   always_ff @(posedge clk) begin
      if (rst) begin
         r_type <= T_NONE;
         r_addr <= '0;
      end else if (w_go) begin
         r_type <= w_sel;
         r_addr <= (w_sel == T_WR) ? r_wr_addr : (w_sel == T_RD) ? r_rd_addr : '0;
      end else if (w_fin) begin
         r_type <= T_NONE;
         r_addr <= '0;
      end
   end

   // Round-robin bit flips only when the shared read/write case decided the grant
   always_ff @(posedge clk) begin
      if (rst) r_rr <= 1'b0;
      else if (w_go & w_rr_hit) r_rr <= ~r_rr;
   end

   // Refresh timer; a new terminal count beats a simultaneous refresh ack
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
      end else begin
         r_cnt  <= (~init_done | w_tick) ? '0 : r_cnt + 1'b1;
         r_pend <= w_tick | (r_pend & ~w_ref_ack);
      end
   end

   // Write address: load beats burst advance; advance wraps to base at max or on overflow
   always_ff @(posedge clk) begin
      if (rst) r_wr_addr <= '0;
      else if (wr_load) r_wr_addr <= wr_base;
      else if (w_fin & (r_type == T_WR))
         r_wr_addr <= (w_wr_nxt >= {1'b0, wr_max}) ? wr_base : w_wr_nxt[ADDR_W-1:0];
   end

   // Read address: same policy as the write side
   always_ff @(posedge clk) begin
      if (rst) r_rd_addr <= '0;
      else if (rd_load) r_rd_addr <= rd_base;
      else if (w_fin & (r_type == T_RD))
         r_rd_addr <= (w_rd_nxt >= {1'b0, rd_max}) ? rd_base : w_rd_nxt[ADDR_W-1:0];
   end
endmodule
